operand_stack: RTL
==================

// Module: operand_stack
// PURPOSE
//  LIFO operand stack of the stack-based processor; sits directly downstream of the
//  8-bit instruction/data memory. PUSH captures memory read_data (or ALU result);
//  POP exposes top-of-stack (TOS) as memory write_data; BINOP replaces TOS/NOS by ALU
//  result. Exposes TOS and next-on-stack (NOS) combinationally to the ALU.
// PARAMETERS
//  WIDTH  8   data width, matches memory word
//  DEPTH  16  number of entries (power of 2, >=2)
//  PTRW   4   log2(DEPTH); count register is PTRW+1 bits
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      asynchronous, active-low reset
//  op         in   2      00 NOP, 01 PUSH, 10 POP, 11 BINOP
//  push_data  in   WIDTH  PUSH operand (memory read_data, valid by posedge after negedge read)
//  alu_res    in   WIDTH  BINOP result, computed from tos/nos
//  tos        out  WIDTH  top entry; 0 when empty
//  nos        out  WIDTH  second entry; 0 when count<2
//  count      out  PTRW+1 number of valid entries, 0..DEPTH
//  empty      out  1      count==0
//  full       out  1      count==DEPTH
//  ovf        out  1      sticky: PUSH attempted while full
//  unf        out  1      sticky: POP while empty, or BINOP while count<2
// BEHAVIOUR
//  Reset (rst=0, async): count=0, empty=1, full=0, ovf=0, unf=0, tos=0, nos=0.
//   Storage array not reset; outputs masked by count. Reset mid-op discards the op.
//  Storage mem[0..DEPTH-1]; entry i valid iff i<count; TOS=mem[count-1], NOS=mem[count-2].
//  tos/nos/empty/full are combinational from count and mem (zero-latency read).
//  PUSH: if !full -> mem[count]<=push_data, count<=count+1; tos=push_data next cycle.
//        if full  -> no state change, ovf<=1.
//  POP:  if !empty -> count<=count-1; caller samples tos in same cycle (before edge).
//        if empty  -> no state change, unf<=1.
//  BINOP: if count>=2 -> mem[count-2]<=alu_res, count<=count-1 (net pop2/push1).
//         else -> no state change, unf<=1.
//  NOP: hold. Exactly one op per cycle; op encoding is exhaustive, no conflicts.
//  ovf/unf clear only on reset. Errors never corrupt count or stored data.
//  Count never wraps: saturates by refusal at 0 and DEPTH.
//  Single-cycle latency for every op; no backpressure, no stall output.
//  Controller contract: PUSH issued in cycle after memory read on negedge, so
//   push_data is stable at the posedge; stack does not register push_data early.
// TESTING
//  1 Reset: drive rst=0 mid-PUSH -> count=0, empty=1, tos=0, ovf=unf=0 immediately.
//  2 PUSH 7, PUSH 10, PUSH 3 -> tos=3, nos=10, count=3; POP -> tos=10, nos=7, count=2.
//  3 Stack 7,10; BINOP with alu_res=17 -> count=1, tos=17, nos=0.
//  4 Fill DEPTH=16 pushes of 0..15 -> full=1, tos=15; 17th PUSH 99 -> ovf=1, tos=15, count=16.
//  5 Empty stack: POP -> unf=1, count=0; PUSH 5 then BINOP -> unf stays 1, tos=5, count=1.
//  6 Random op/data stream vs. reference queue model, 2000 cycles, DEPTH=4 -> tos/nos/count/flags match.

Source files
------------

// File: rtl/operand_stack.sv
// LIFO operand stack for the stack processor: PUSH/POP/BINOP with combinational
// TOS/NOS views for the ALU, sticky overflow/underflow flags, and refusal at the bounds.
module operand_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTRW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [PTRW:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned CW = PTRW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_PUSH  = 2'b01,
    OP_POP   = 2'b10,
    OP_BINOP = 2'b11
  } op_e;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  op_e              w_op;
  logic             w_empty;
  logic             w_full;
  logic             w_ge2;
  logic [PTRW-1:0]  w_wr_idx;
  logic [PTRW-1:0]  w_tos_idx;
  logic [PTRW-1:0]  w_nos_idx;
  logic             w_push_ok;
  logic             w_bin_ok;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [CW-1:0]    w_count_nxt;

  assign w_op      = op_e'(op);
  assign w_empty   = (r_count == CW'(0));
  assign w_full    = (r_count == DEPTH_C);
  assign w_ge2     = (r_count >= CW'(2));
  assign w_wr_idx  = PTRW'(r_count);
  assign w_tos_idx = PTRW'(r_count - CW'(1));
  assign w_nos_idx = PTRW'(r_count - CW'(2));

  // Op decode: legal ops move the count by one, illegal ones only raise a flag.
  always_comb begin
    w_push_ok   = 1'b0;
    w_bin_ok    = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    w_count_nxt = r_count;
    case (w_op)
      OP_PUSH: begin
        if (!w_full) begin
          w_push_ok   = 1'b1;
          w_count_nxt = r_count + CW'(1);
        end else begin
          w_ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        if (!w_empty) begin
          w_count_nxt = r_count - CW'(1);
        end else begin
          w_unf_set = 1'b1;
        end
      end
      OP_BINOP: begin
        if (w_ge2) begin
          w_bin_ok    = 1'b1;
          w_count_nxt = r_count - CW'(1);
        end else begin
          w_unf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_unf_set) r_unf <= 1'b1;
    end
  end

  // Storage is not reset; every read is masked by the count.
  always_ff @(posedge clk) begin
    if (rst && w_push_ok) begin
      r_mem[w_wr_idx] <= push_data;
    end else if (rst && w_bin_ok) begin
      r_mem[w_nos_idx] <= alu_res;
    end
  end

  assign tos   = w_empty ? '0 : r_mem[w_tos_idx];
  assign nos   = w_ge2 ? r_mem[w_nos_idx] : '0;
  assign count = r_count;
  assign empty = w_empty;
  assign full  = w_full;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule
